// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD controller: register map,
// status/control bit positions, sequencer states and FIFO entry layout.
package lcd_pkg;

  // Bus register addresses
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CMD  = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  // Status register bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 8;

  // Control register bit positions
  localparam int CTRL_ON      = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_FLUSH   = 2;

  // Command FIFO entry: {nib_only, rs, byte}
  localparam int ENTRY_W   = 10;
  localparam int ENTRY_NIB = 9;
  localparam int ENTRY_RS  = 8;

  // Commands that need the long execution wait (clear display, return home)
  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  // Bus sequencer states
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EN_HI,
    EN_LO,
    WAIT
  } lcd_state_t;

  // True when the transfer is a command that needs the long execution wait
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] cmd_byte);
    return !rs && (cmd_byte == OP_CLEAR || cmd_byte == OP_HOME || cmd_byte == OP_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_ctrl_fifo.sv
// Synchronous FIFO holding queued LCD transfers. A push is accepted only
// when not full at that edge; a pop in the same cycle does not make room.
module lcd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; flush discards everything queued
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lcd_ctrl.sv
// Character-LCD controller: bus register file, command FIFO and a hardware
// sequencer producing address setup, enable pulse and execution wait timing.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int T_AS        = 4,
  parameter int T_EN        = 25,
  parameter int T_EXEC      = 2500,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        lcd_on,
  output logic        lcd_en,
  output logic        lcd_rw,
  output logic        lcd_rs,
  output logic [7:0]  lcd_data
);

  localparam int CW  = $clog2(T_EXEC_LONG + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam bit NIBBLE_MODE = (DATA_BITS == 4);

  localparam logic [CW-1:0] AS_LD   = CW'(T_AS - 1);
  localparam logic [CW-1:0] EN_LD   = CW'(T_EN - 1);
  localparam logic [CW-1:0] EXEC_LD = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LONG_LD = CW'(T_EXEC_LONG - 1);

  lcd_state_t         state_q;
  lcd_state_t         state_d;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  logic               pop;
  logic               load_first;
  logic               load_low;
  logic [7:0]         cur_byte;
  logic               cur_nib_only;
  logic               low_phase;
  logic               overflow;

  logic               bus_wr;
  logic               bus_rd;
  logic               push;
  logic               ctrl_wr;
  logic               flush;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] fifo_rd;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FCW-1:0]     fifo_count;
  logic [7:0]         stat_count;
  logic               busy;
  logic [22:0]        unused_data_in;

  assign ack     = stb;
  assign lcd_rw  = 1'b0;
  assign bus_wr  = stb && we;
  assign bus_rd  = stb && !we;
  assign push    = bus_wr && (addr == ADDR_DATA || addr == ADDR_CMD);
  assign ctrl_wr = bus_wr && (addr == ADDR_CTRL);
  assign flush   = ctrl_wr && data_in[CTRL_FLUSH];
  assign busy    = (state_q != IDLE) || !fifo_empty;
  assign stat_count     = 8'(fifo_count);
  assign unused_data_in = data_in[31:9];

  // Data writes always set rs; command writes carry the nibble-only flag in bit 8
  always_comb begin
    push_entry = '0;
    if (addr == ADDR_DATA) push_entry = {1'b0, 1'b1, data_in[7:0]};
    else                   push_entry = {data_in[8], 1'b0, data_in[7:0]};
  end

  lcd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (push_entry),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Control register and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_on   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (ctrl_wr) lcd_on <= data_in[CTRL_ON];
      if (push && fifo_full)                       overflow <= 1'b1;
      else if (ctrl_wr && data_in[CTRL_CLR_OVF])   overflow <= 1'b0;
    end
  end

  // Bus read mux; returns zero whenever no read is in progress
  always_comb begin
    data_out = '0;
    if (bus_rd) begin
      case (addr)
        ADDR_STAT: begin
          data_out[STAT_BUSY] = busy;
          data_out[STAT_FULL] = fifo_full;
          data_out[STAT_OVF]  = overflow;
          data_out[STAT_CNT_LSB +: 8] = stat_count;
        end
        ADDR_CTRL: data_out[CTRL_ON] = lcd_on;
        default:   data_out = '0;
      endcase
    end
  end

  // Sequencer state, timing counter and LCD bus registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lcd_en       <= 1'b0;
      lcd_rs       <= 1'b0;
      lcd_data     <= '0;
      cur_byte     <= '0;
      cur_nib_only <= 1'b0;
      low_phase    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lcd_en  <= (state_d == EN_HI);
      if (load_first) begin
        lcd_rs       <= fifo_rd[ENTRY_RS];
        cur_byte     <= fifo_rd[7:0];
        cur_nib_only <= fifo_rd[ENTRY_NIB];
        low_phase    <= 1'b0;
        lcd_data     <= NIBBLE_MODE ? {fifo_rd[7:4], 4'h0} : fifo_rd[7:0];
      end else if (load_low) begin
        lcd_data  <= {cur_byte[3:0], 4'h0};
        low_phase <= 1'b1;
      end
    end
  end

  // Next-state logic: each timed state runs until the counter reaches zero
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    load_first = 1'b0;
    load_low   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          load_first = 1'b1;
          state_d    = SETUP;
          cnt_d      = AS_LD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = EN_HI;
          cnt_d   = EN_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      EN_HI: begin
        if (cnt_q == '0) begin
          state_d = EN_LO;
          cnt_d   = EN_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      EN_LO: begin
        if (cnt_q == '0) begin
          if (NIBBLE_MODE && !low_phase && !cur_nib_only) begin
            load_low = 1'b1;
            state_d  = SETUP;
            cnt_d    = AS_LD;
          end else begin
            state_d = WAIT;
            cnt_d   = is_long_cmd(lcd_rs, cur_byte) ? LONG_LD : EXEC_LD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl: one 8-bit and one 4-bit instance on a shared bus.
module tb_lcd_ctrl;
  import lcd_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAS   = 2;
  localparam int TEN   = 3;
  localparam int TEXEC = 10;
  localparam int TLONG = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb8 = 1'b0;
  logic        stb4 = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] data_in = 32'd0;

  logic [31:0] dout8, dout4;
  logic        ack8, ack4, on8, on4, en8, en4, rw8, rw4, rs8, rs4;
  logic [7:0]  dat8, dat4;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  lcd_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .T_AS(TAS), .T_EN(TEN),
             .T_EXEC(TEXEC), .T_EXEC_LONG(TLONG)) dut8 (
    .clk(clk), .rst(rst), .stb(stb8), .we(we), .addr(addr), .data_in(data_in),
    .data_out(dout8), .ack(ack8), .lcd_on(on8), .lcd_en(en8), .lcd_rw(rw8),
    .lcd_rs(rs8), .lcd_data(dat8));

  lcd_ctrl #(.DATA_BITS(4), .FIFO_DEPTH(DEPTH), .T_AS(TAS), .T_EN(TEN),
             .T_EXEC(TEXEC), .T_EXEC_LONG(TLONG)) dut4 (
    .clk(clk), .rst(rst), .stb(stb4), .we(we), .addr(addr), .data_in(data_in),
    .data_out(dout4), .ack(ack4), .lcd_on(on4), .lcd_en(en4), .lcd_rw(rw4),
    .lcd_rs(rs4), .lcd_data(dat4));

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Enable-pulse monitor per instance: data at rise, width, fall cycle, stability
  logic       en_w   [2];
  logic       rs_w   [2];
  logic [7:0] dat_w  [2];
  logic       en_prev[2] = '{1'b0, 1'b0};
  logic [7:0] hold_dat[2];
  logic       hold_rs [2];
  int         hi_len  [2] = '{0, 0};
  int         pcnt    [2] = '{0, 0};
  int         pfall   [2] = '{0, 0};
  int         unstable[2] = '{0, 0};
  logic [7:0] pdat    [2][64];
  logic       prs     [2][64];
  int         pwid    [2][64];

  assign en_w[0] = en8;  assign en_w[1] = en4;
  assign rs_w[0] = rs8;  assign rs_w[1] = rs4;
  assign dat_w[0] = dat8; assign dat_w[1] = dat4;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (en_w[i] && !en_prev[i]) begin
        if (pcnt[i] < 64) begin
          pdat[i][pcnt[i]] <= dat_w[i];
          prs[i][pcnt[i]]  <= rs_w[i];
        end
        hold_dat[i] <= dat_w[i];
        hold_rs[i]  <= rs_w[i];
        hi_len[i]   <= 1;
      end else if (en_w[i]) begin
        hi_len[i] <= hi_len[i] + 1;
        if (dat_w[i] != hold_dat[i] || rs_w[i] != hold_rs[i]) unstable[i] <= unstable[i] + 1;
      end else if (en_prev[i]) begin
        if (pcnt[i] < 64) pwid[i][pcnt[i]] <= hi_len[i];
        pcnt[i]  <= pcnt[i] + 1;
        pfall[i] <= cyc;
      end
      en_prev[i] <= en_w[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus write to one instance; starts and ends at a falling edge
  task automatic applyStimulus(input int sel, input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; data_in = d;
    if (sel == 0) stb8 = 1'b1; else stb4 = 1'b1;
    @(negedge clk);
    stb8 = 1'b0; stb4 = 1'b0; we = 1'b0; data_in = 32'd0;
  endtask

  task automatic readReg(input int sel, input logic [1:0] a, output logic [31:0] v);
    we = 1'b0; addr = a;
    if (sel == 0) stb8 = 1'b1; else stb4 = 1'b1;
    #1;
    v = (sel == 0) ? dout8 : dout4;
    stb8 = 1'b0; stb4 = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitIdle(input int sel, input int limit, output int idle_cyc);
    logic [31:0] v;
    int n;
    v = 32'd1;
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      readReg(sel, ADDR_STAT, v);
      n++;
      if (v[STAT_BUSY] == 1'b0) break;
    end
    idle_cyc = cyc;
    checkOutput("idle_reached", 32'(v[STAT_BUSY]), 32'd0);
  endtask

  task automatic waitEn(input int sel, input int limit);
    int n;
    n = 0;
    while (n < limit && ((sel == 0) ? en8 : en4) == 1'b0) begin
      @(negedge clk);
      n++;
    end
    checkOutput("en_rise_seen", 32'((sel == 0) ? en8 : en4), 32'd1);
  endtask

  initial begin
    logic [31:0] v;
    int ic, base;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    checkOutput("rst_en8", 32'(en8), 32'd0);
    checkOutput("rst_data8", 32'(dat8), 32'd0);
    checkOutput("rst_rs8", 32'(rs8), 32'd0);
    checkOutput("rst_on8", 32'(on8), 32'd0);
    checkOutput("rst_rw4", 32'(rw4), 32'd0);
    checkOutput("idle_dout8", dout8, 32'd0);
    checkOutput("idle_ack8", 32'(ack8), 32'd0);
    readReg(0, ADDR_STAT, v);
    checkOutput("rst_status8", v, 32'd0);
    readReg(0, ADDR_DATA, v);
    checkOutput("read_addr0", v, 32'd0);

    // 8-bit data write timing
    @(negedge clk);
    applyStimulus(0, ADDR_DATA, 32'h41);
    checkOutput("t1_data_pre", 32'(dat8), 32'd0);
    waitCycles(1);
    checkOutput("t1_data", 32'(dat8), 32'h41);
    checkOutput("t1_rs", 32'(rs8), 32'd1);
    checkOutput("t1_en_setup0", 32'(en8), 32'd0);
    waitCycles(1);
    checkOutput("t1_en_setup1", 32'(en8), 32'd0);
    waitCycles(1);
    checkOutput("t1_en_rise", 32'(en8), 32'd1);
    waitCycles(2);
    checkOutput("t1_en_last", 32'(en8), 32'd1);
    waitCycles(1);
    checkOutput("t1_en_fall", 32'(en8), 32'd0);
    waitCycles(12);
    readReg(0, ADDR_STAT, v);
    checkOutput("t1_busy_late", v, 32'd1);
    waitCycles(1);
    readReg(0, ADDR_STAT, v);
    checkOutput("t1_idle", v, 32'd0);
    checkOutput("t1_data_hold", 32'(dat8), 32'h41);

    // 4-bit mode: full command then nibble-only command
    @(negedge clk);
    applyStimulus(1, ADDR_CMD, 32'h28);
    waitIdle(1, 300, ic);
    checkOutput("t2_pulses", 32'(pcnt[1]), 32'd2);
    checkOutput("t2_hi_nib", 32'(pdat[1][0]), 32'h20);
    checkOutput("t2_lo_nib", 32'(pdat[1][1]), 32'h80);
    checkOutput("t2_rs0", 32'(prs[1][0]), 32'd0);
    checkOutput("t2_rs1", 32'(prs[1][1]), 32'd0);
    checkOutput("t2_width", 32'(pwid[1][1]), 32'(TEN));
    applyStimulus(1, ADDR_CMD, 32'h130);
    waitIdle(1, 300, ic);
    checkOutput("t2_nibonly_pulses", 32'(pcnt[1]), 32'd3);
    checkOutput("t2_nibonly_data", 32'(pdat[1][2]), 32'h30);

    // Long vs normal execution wait, measured from EN fall to idle
    applyStimulus(0, ADDR_CMD, 32'h01);
    waitIdle(0, 300, ic);
    checkOutput("t3_long_wait", 32'(ic - pfall[0]), 32'(TEN + TLONG));
    applyStimulus(0, ADDR_CMD, 32'h06);
    waitIdle(0, 300, ic);
    checkOutput("t3_short_wait", 32'(ic - pfall[0]), 32'(TEN + TEXEC));

    // Overflow: DEPTH+2 back-to-back bytes, one popped immediately, one dropped
    base = pcnt[0];
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, ADDR_DATA, 32'h10 + 32'(i));
    readReg(0, ADDR_STAT, v);
    checkOutput("t4_status_full", v, 32'h0000_0407);
    applyStimulus(0, ADDR_CTRL, 32'h3);
    readReg(0, ADDR_STAT, v);
    checkOutput("t4_ovf_cleared", v, 32'h0000_0403);
    readReg(0, ADDR_CTRL, v);
    checkOutput("t4_ctrl_read", v, 32'd1);
    checkOutput("t4_lcd_on", 32'(on8), 32'd1);
    waitIdle(0, 500, ic);
    checkOutput("t4_pulses", 32'(pcnt[0] - base), 32'(DEPTH + 1));
    checkOutput("t4_first", 32'(pdat[0][base]), 32'h10);
    checkOutput("t4_last", 32'(pdat[0][base + DEPTH]), 32'h14);

    // Flush during EN_HI: current pulse completes intact, nothing else sent
    base = pcnt[0];
    for (int i = 0; i < 5; i++) applyStimulus(0, ADDR_DATA, 32'h50 + 32'(i));
    waitEn(0, 50);
    applyStimulus(0, ADDR_CTRL, 32'h5);
    checkOutput("t5_en_kept", 32'(en8), 32'd1);
    readReg(0, ADDR_STAT, v);
    checkOutput("t5_status_flushed", v, 32'h0000_0001);
    waitIdle(0, 300, ic);
    checkOutput("t5_pulses", 32'(pcnt[0] - base), 32'd1);
    checkOutput("t5_data", 32'(pdat[0][base]), 32'h50);
    checkOutput("t5_width", 32'(pwid[0][base]), 32'(TEN));
    checkOutput("stable8", 32'(unstable[0]), 32'd0);
    checkOutput("stable4", 32'(unstable[1]), 32'd0);

    // Reset mid-EN_HI with entries still queued
    for (int i = 0; i < 3; i++) applyStimulus(0, ADDR_DATA, 32'h60 + 32'(i));
    waitEn(0, 50);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_en_reset", 32'(en8), 32'd0);
    checkOutput("t6_data_reset", 32'(dat8), 32'd0);
    checkOutput("t6_on_reset", 32'(on8), 32'd0);
    readReg(0, ADDR_STAT, v);
    checkOutput("t6_status_reset", v, 32'd0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
